// File: rtl/trap_unit_pkg.sv
// Shared definitions for the machine-mode trap unit: CSR addresses, cause codes,
// mstatus/mie/mip bit positions, FSM states and the mstatus read-view helper.
package trap_unit_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CSR_AW  = 12;

  localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MIE     = 12'h304;
  localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;
  localparam logic [CSR_AW-1:0] CSR_MTVAL   = 12'h343;
  localparam logic [CSR_AW-1:0] CSR_MIP     = 12'h344;

  localparam logic [XLEN-1:0] CAUSE_ILLEGAL    = 32'd2;
  localparam logic [XLEN-1:0] CAUSE_BREAKPOINT = 32'd3;
  localparam logic [XLEN-1:0] CAUSE_ECALL_M    = 32'd11;
  localparam logic [XLEN-1:0] CAUSE_EXT_IRQ    = 32'h8000_000B;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;
  localparam int unsigned MIE_MEIE     = 11;
  localparam int unsigned MIP_MEIP     = 11;

  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } trap_state_e;

  // mstatus as software sees it: MPP fixed at machine mode, only MIE/MPIE live.
  function automatic logic [XLEN-1:0] mstatus_pack(input logic mie, input logic mpie);
    logic [XLEN-1:0] v;
    v = '0;
    v[12:11]         = 2'b11;
    v[MSTATUS_MIE]   = mie;
    v[MSTATUS_MPIE]  = mpie;
    return v;
  endfunction

endpackage

// File: rtl/trap_unit_irq_sync.sv
// Reset-to-0 multi-flop synchronizer bringing the asynchronous irq_ext into clk.
module trap_unit_irq_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic irq_async,
  output logic irq_sync
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], irq_async};
    end
  end

  assign irq_sync = sync_q[STAGES-1];

endmodule

// File: rtl/trap_unit.sv
// Machine-mode trap responder: owns the trap CSRs, takes exceptions/interrupts/MRET
// and issues a one-cycle flush + redirect. Define TRAP_VECTORED_EN for vectored mtvec.
module trap_unit
  import trap_unit_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET     = 32'h0000_0000,
  parameter int unsigned IRQ_SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_valid,
  input  logic [XLEN-1:0]   inst_pc,
  input  logic [XLEN-1:0]   inst_word,
  input  logic              illegal_inst,
  input  logic              is_ecall,
  input  logic              is_ebreak,
  input  logic              is_mret,
  input  logic              irq_ext,
  input  logic [CSR_AW-1:0] csr_addr,
  input  logic              csr_we,
  input  logic [XLEN-1:0]   csr_wdata,
  output logic [XLEN-1:0]   csr_rdata,
  output logic              csr_hit,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              flush,
  output logic              busy
);

  trap_state_e     state_q;
  logic            mie_q;
  logic            mpie_q;
  logic            meie_q;
  logic [29:0]     mtvec_base_q;
  logic [1:0]      mtvec_mode;
  logic [29:0]     mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mtval_q;

  logic            irq_s;
  logic            irq_pend;
  logic            take_irq;
  logic            take_exc;
  logic            take_mret;
  logic            accept;
  logic            csr_wr;
  logic [XLEN-1:0] cause_nxt;
  logic [XLEN-1:0] tval_nxt;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] target;

  trap_unit_irq_sync #(.STAGES(IRQ_SYNC_STAGES)) u_irq_sync (
    .clk       (clk),
    .reset     (reset),
    .irq_async (irq_ext),
    .irq_sync  (irq_s)
  );

  // Event arbitration: interrupt beats exceptions, exceptions beat MRET.
  always_comb begin
    irq_pend  = irq_s & meie_q & mie_q;
    take_irq  = 1'b0;
    take_exc  = 1'b0;
    take_mret = 1'b0;
    cause_nxt = '0;
    tval_nxt  = '0;
    if (state_q == ST_IDLE && inst_valid) begin
      if (irq_pend) begin
        take_irq  = 1'b1;
        cause_nxt = CAUSE_EXT_IRQ;
      end else if (illegal_inst) begin
        take_exc  = 1'b1;
        cause_nxt = CAUSE_ILLEGAL;
        tval_nxt  = inst_word;
      end else if (is_ebreak) begin
        take_exc  = 1'b1;
        cause_nxt = CAUSE_BREAKPOINT;
        tval_nxt  = inst_pc;
      end else if (is_ecall) begin
        take_exc  = 1'b1;
        cause_nxt = CAUSE_ECALL_M;
      end else if (is_mret) begin
        take_mret = 1'b1;
      end
    end
    accept = take_irq | take_exc | take_mret;
    csr_wr = csr_we & (state_q == ST_IDLE) & ~accept;

    base   = {mtvec_base_q, 2'b00};
    target = base;
    if (take_mret) begin
      target = {mepc_q, 2'b00};
    end else if (take_irq && mtvec_mode == MTVEC_MODE_VECTORED) begin
      target = base + {25'd0, cause_nxt[4:0], 2'b00};
    end
  end

`ifdef TRAP_VECTORED_EN
  logic [1:0] mtvec_mode_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtvec_mode_q <= MTVEC_RESET[1:0];
    end else if (csr_wr && csr_addr == CSR_MTVEC) begin
      mtvec_mode_q <= csr_wdata[1:0];
    end
  end

  assign mtvec_mode = mtvec_mode_q;
`else
  assign mtvec_mode = 2'b00;
`endif

  // FSM, registered redirect outputs and trap CSR updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      redirect_valid <= 1'b0;
      flush          <= 1'b0;
      busy           <= 1'b0;
      redirect_pc    <= '0;
      mie_q          <= 1'b0;
      mpie_q         <= 1'b0;
      meie_q         <= 1'b0;
      mtvec_base_q   <= MTVEC_RESET[31:2];
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
    end else begin
      state_q        <= ST_IDLE;
      redirect_valid <= 1'b0;
      flush          <= 1'b0;
      busy           <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q        <= ST_REDIRECT;
            redirect_valid <= 1'b1;
            flush          <= 1'b1;
            busy           <= 1'b1;
            redirect_pc    <= target;
            if (take_mret) begin
              mie_q  <= mpie_q;
              mpie_q <= 1'b1;
            end else begin
              mepc_q   <= inst_pc[31:2];
              mpie_q   <= mie_q;
              mie_q    <= 1'b0;
              mcause_q <= cause_nxt;
              mtval_q  <= tval_nxt;
            end
          end else if (csr_wr) begin
            case (csr_addr)
              CSR_MSTATUS: begin
                mie_q  <= csr_wdata[MSTATUS_MIE];
                mpie_q <= csr_wdata[MSTATUS_MPIE];
              end
              CSR_MIE:    meie_q       <= csr_wdata[MIE_MEIE];
              CSR_MTVEC:  mtvec_base_q <= csr_wdata[31:2];
              CSR_MEPC:   mepc_q       <= csr_wdata[31:2];
              CSR_MCAUSE: mcause_q     <= csr_wdata;
              CSR_MTVAL:  mtval_q      <= csr_wdata;
              default: ;
            endcase
          end
        end
        ST_REDIRECT: ;
        default: ;
      endcase
    end
  end

  // Software read port; unowned addresses read zero.
  always_comb begin
    csr_rdata = '0;
    csr_hit   = 1'b1;
    case (csr_addr)
      CSR_MSTATUS: csr_rdata = mstatus_pack(mie_q, mpie_q);
      CSR_MIE:     csr_rdata[MIE_MEIE] = meie_q;
      CSR_MTVEC:   csr_rdata = {mtvec_base_q, mtvec_mode};
      CSR_MEPC:    csr_rdata = {mepc_q, 2'b00};
      CSR_MCAUSE:  csr_rdata = mcause_q;
      CSR_MTVAL:   csr_rdata = mtval_q;
      CSR_MIP:     csr_rdata[MIP_MEIP] = irq_s;
      default:     csr_hit = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_trap_unit.sv
// Directed self-checking bench for trap_unit; expectations follow TRAP_VECTORED_EN.
module tb_trap_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_word;
  logic        illegal_inst;
  logic        is_ecall;
  logic        is_ebreak;
  logic        is_mret;
  logic        irq_ext;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_hit;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] MSTATUS_BASE = 32'h0000_1800;
`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] EXP_IRQ_PC  = 32'h0000_032C;
  localparam logic [31:0] EXP_MTVEC01 = 32'h0000_0201;
`else
  localparam logic [31:0] EXP_IRQ_PC  = 32'h0000_0300;
  localparam logic [31:0] EXP_MTVEC01 = 32'h0000_0200;
`endif

  trap_unit dut (
    .clk            (clk),
    .reset          (reset),
    .inst_valid     (inst_valid),
    .inst_pc        (inst_pc),
    .inst_word      (inst_word),
    .illegal_inst   (illegal_inst),
    .is_ecall       (is_ecall),
    .is_ebreak      (is_ebreak),
    .is_mret        (is_mret),
    .irq_ext        (irq_ext),
    .csr_addr       (csr_addr),
    .csr_we         (csr_we),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .csr_hit        (csr_hit),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic csr_check(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_addr = addr;
    #1;
    check(tag, csr_rdata, exp);
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    @(negedge clk);
    csr_addr  = addr;
    csr_wdata = data;
    csr_we    = 1'b1;
    @(negedge clk);
    csr_we    = 1'b0;
  endtask

  // Commits one instruction (optionally with a coincident CSR write) and checks the redirect pulse.
  task automatic commit(input string tag, input logic [31:0] pc, input logic [31:0] word,
                        input logic ill, input logic ec, input logic eb, input logic mr,
                        input logic we, input logic [11:0] waddr, input logic [31:0] wdata,
                        input logic [31:0] exp_pc);
    @(negedge clk);
    inst_valid   = 1'b1;
    inst_pc      = pc;
    inst_word    = word;
    illegal_inst = ill;
    is_ecall     = ec;
    is_ebreak    = eb;
    is_mret      = mr;
    csr_we       = we;
    csr_addr     = waddr;
    csr_wdata    = wdata;
    @(negedge clk);
    inst_valid   = 1'b0;
    illegal_inst = 1'b0;
    is_ecall     = 1'b0;
    is_ebreak    = 1'b0;
    is_mret      = 1'b0;
    csr_we       = 1'b0;
    #1;
    check({tag, ".rv"}, 32'(redirect_valid), 32'd1);
    check({tag, ".flush"}, 32'(flush), 32'd1);
    check({tag, ".busy"}, 32'(busy), 32'd1);
    check({tag, ".pc"}, redirect_pc, exp_pc);
    @(negedge clk);
    #1;
    check({tag, ".rv_off"}, 32'(redirect_valid), 32'd0);
    check({tag, ".busy_off"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; inst_valid = 1'b0; inst_pc = '0; inst_word = '0;
    illegal_inst = 1'b0; is_ecall = 1'b0; is_ebreak = 1'b0; is_mret = 1'b0;
    irq_ext = 1'b0; csr_addr = '0; csr_we = 1'b0; csr_wdata = '0;

    repeat (2) @(negedge clk);
    #1;
    check("rst.rv", 32'(redirect_valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.pc", redirect_pc, 32'd0);
    csr_check("rst.mstatus", 12'h300, MSTATUS_BASE);
    csr_check("rst.mtvec", 12'h305, 32'd0);
    csr_addr = 12'h7C0;
    #1;
    check("unowned.hit", 32'(csr_hit), 32'd0);
    check("unowned.rdata", csr_rdata, 32'd0);
    csr_addr = 12'h342;
    #1;
    check("owned.hit", 32'(csr_hit), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // mtvec mode bits and mepc alignment
    csr_write(12'h305, 32'h0000_0201);
    csr_check("mtvec.mode", 12'h305, EXP_MTVEC01);
    csr_write(12'h341, 32'h0000_0123);
    csr_check("mepc.align", 12'h341, 32'h0000_0120);

    // illegal instruction
    csr_write(12'h305, 32'h0000_0200);
    commit("ill", 32'h100, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 12'h0, 32'h0, 32'h200);
    csr_check("ill.mcause", 12'h342, 32'd2);
    csr_check("ill.mtval", 12'h343, 32'hFFFF_FFFF);
    csr_check("ill.mepc", 12'h341, 32'h100);

    // ECALL with MIE=1, then MRET
    csr_write(12'h300, 32'h0000_0008);
    csr_check("mstatus.wr", 12'h300, MSTATUS_BASE | 32'h8);
    commit("ecall", 32'h40, 32'h0000_0073, 0, 1, 0, 0, 0, 12'h0, 32'h0, 32'h200);
    csr_check("ecall.mcause", 12'h342, 32'd11);
    csr_check("ecall.mtval", 12'h343, 32'd0);
    csr_check("ecall.mstatus", 12'h300, MSTATUS_BASE | 32'h80);
    commit("mret1", 32'h204, 32'h3020_0073, 0, 0, 0, 1, 0, 12'h0, 32'h0, 32'h40);
    csr_check("mret1.mstatus", 12'h300, MSTATUS_BASE | 32'h88);

    // EBREAK
    commit("ebreak", 32'h44, 32'h0010_0073, 0, 0, 1, 0, 0, 12'h0, 32'h0, 32'h200);
    csr_check("ebreak.mcause", 12'h342, 32'd3);
    csr_check("ebreak.mtval", 12'h343, 32'h44);
    commit("mret2", 32'h208, 32'h3020_0073, 0, 0, 0, 1, 0, 12'h0, 32'h0, 32'h44);

    // external interrupt through the synchronizer
    csr_write(12'h304, 32'h0000_0800);
    csr_check("mie.wr", 12'h304, 32'h800);
    csr_write(12'h305, 32'h0000_0301);
    @(negedge clk);
    irq_ext = 1'b1;
    @(negedge clk);
    csr_check("mip.sync1", 12'h344, 32'h0);
    @(negedge clk);
    csr_check("mip.sync2", 12'h344, 32'h800);
    commit("irq", 32'h80, 32'h00B5_0533, 0, 0, 0, 0, 0, 12'h0, 32'h0, EXP_IRQ_PC);
    csr_check("irq.mcause", 12'h342, 32'h8000_000B);
    csr_check("irq.mepc", 12'h341, 32'h80);
    csr_check("irq.mtval", 12'h343, 32'h0);
    csr_check("irq.mstatus", 12'h300, MSTATUS_BASE | 32'h80);

    // MRET re-enables MIE; ECALL then loses to the pending interrupt, CSR write dropped
    commit("mret3", 32'h310, 32'h3020_0073, 0, 0, 0, 1, 0, 12'h0, 32'h0, 32'h80);
    commit("ecall_irq", 32'h88, 32'h0000_0073, 0, 1, 0, 0, 1, 12'h341, 32'h999, EXP_IRQ_PC);
    csr_check("ecall_irq.mcause", 12'h342, 32'h8000_000B);
    csr_check("ecall_irq.mepc", 12'h341, 32'h88);
    irq_ext = 1'b0;

    // reset asserted while REDIRECT is active
    @(negedge clk);
    inst_valid = 1'b1; inst_pc = 32'h120; inst_word = 32'h0; illegal_inst = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0; illegal_inst = 1'b0;
    #1;
    check("rstmid.rv_before", 32'(redirect_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("rstmid.rv", 32'(redirect_valid), 32'd0);
    check("rstmid.flush", 32'(flush), 32'd0);
    check("rstmid.busy", 32'(busy), 32'd0);
    check("rstmid.pc", redirect_pc, 32'd0);
    csr_check("rstmid.mstatus", 12'h300, MSTATUS_BASE);
    csr_check("rstmid.mie", 12'h304, 32'd0);
    csr_check("rstmid.mtvec", 12'h305, 32'd0);
    csr_check("rstmid.mepc", 12'h341, 32'd0);
    csr_check("rstmid.mcause", 12'h342, 32'd0);
    csr_check("rstmid.mtval", 12'h343, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
